// File: rtl/asig_pad_arbiter_pkg.sv
// asig_arb_pkg: state type, counter sizing and default timing shared by the pad arbiter
package asig_arb_pkg;
  typedef enum logic [1:0] {IDLE, MAKE, GRANTED, BREAK} arb_state_t;
  localparam int DEF_BREAK_CYC  = 8;
  localparam int DEF_SETTLE_CYC = 16;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/asig_pad_arbiter_if.sv
// asig_pad_arbiter_if: requester/pad-control bundle between the requesters and the pad arbiter
interface asig_pad_arbiter_if #(parameter int N_REQ = 4);
  logic                     pwr_good;
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         sw_en;
  logic [N_REQ-1:0]         revoked;
  logic [$clog2(N_REQ)-1:0] owner;
  logic                     busy;
  modport master (output pwr_good, req, input gnt, sw_en, revoked, owner, busy);
  modport slave  (input pwr_good, req, output gnt, sw_en, revoked, owner, busy);
endinterface

// File: rtl/asig_pad_arbiter_rr_pick.sv
// asig_rr_pick: combinational round-robin picker, first requester at or after ptr wins
module asig_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          valid
);
  logic [IW:0] s;
  // scan from farthest to nearest so the nearest requester is the last write
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    valid   = 1'b0;
    s       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      s = (s >= (IW+1)'(N)) ? s - (IW+1)'(N) : s;
      if (req[s[IW-1:0]]) begin
        win_oh  = N'(1) << s[IW-1:0];
        win_idx = s[IW-1:0];
        valid   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/asig_pad_arbiter.sv
// asig_pad_arbiter: round-robin owner of a shared 5V analog pad with break-before-make
// switch sequencing, settle delay before grant and optional hold-time preemption
module asig_pad_arbiter
  import asig_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int BREAK_CYC  = DEF_BREAK_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int MAX_HOLD   = 0
) (
  input logic               CLK,
  input logic               RN,
  asig_pad_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_w(BREAK_CYC, SETTLE_CYC, MAX_HOLD);
  arb_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, hold_q, hold_d, hold_inc;
  logic [N_REQ-1:0] gnt_q, gnt_d, sw_en_q, sw_en_d, revoked_q, revoked_d;
  logic [N_REQ-1:0] own_oh, pick_oh;
  logic [IW-1:0]    owner_q, owner_d, ptr, pick_idx;
  logic             busy_q, busy_d, pick_valid, to_brk;
  assign own_oh = N_REQ'(1) << owner_q;
  assign ptr    = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
  asig_rr_pick #(.N(N_REQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );
  // every path that opens the switch funnels through to_brk so the break timer always reloads
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    sw_en_d   = sw_en_q;
    revoked_d = '0;
    hold_inc  = hold_q + CW'(1);
    to_brk    = !bus.pwr_good;
    if (bus.pwr_good) begin
      case (state_q)
        IDLE: if (pick_valid) begin
          state_d = MAKE;
          cnt_d   = CW'(SETTLE_CYC);
          owner_d = pick_idx;
          sw_en_d = pick_oh;
        end
        MAKE: if (!bus.req[owner_q]) to_brk = 1'b1;
          else if (cnt_q == CW'(1)) begin
            state_d = GRANTED;
            gnt_d   = own_oh;
            hold_d  = '0;
          end else cnt_d = cnt_q - CW'(1);
        GRANTED: if (!bus.req[owner_q]) to_brk = 1'b1;
          else if (MAX_HOLD > 0 && |(bus.req & ~own_oh)) begin
            if (hold_inc == CW'(MAX_HOLD)) begin
              to_brk    = 1'b1;
              revoked_d = own_oh;
            end else hold_d = hold_inc;
          end else hold_d = '0;
        BREAK: if (cnt_q == CW'(1)) state_d = IDLE;
          else cnt_d = cnt_q - CW'(1);
        default: state_d = IDLE;
      endcase
    end
    if (to_brk) begin
      state_d = BREAK;
      cnt_d   = CW'(BREAK_CYC);
      gnt_d   = '0;
      sw_en_d = '0;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      sw_en_q   <= '0;
      revoked_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      sw_en_q   <= sw_en_d;
      revoked_q <= revoked_d;
      busy_q    <= busy_d;
    end
  assign bus.gnt     = gnt_q;
  assign bus.sw_en   = sw_en_q;
  assign bus.revoked = revoked_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
endmodule
